cpu_datapath: RTL and testbench
===============================

# cpu_datapath

Single-bus 32-bit CPU datapath: sixteen general registers, HI/LO, PC, IR, MAR, MDR, the Y operand latch, a 64-bit Z result register with separately loadable ZHI/ZLO halves, and an ALU. All sources share one 32-bit bus (BusMuxOut), driven by a priority-encoded set of one-hot "out" strobes. An external control unit or bench sequences it with "in"/"out" strobes, one register transfer per clock.

## Interface
No parameters.
- clk  in  1  clock; all state updates on rising edge
- clr  in  1  asynchronous, active-low reset; low clears every register to 0
- R0in..R15in  in  1 each  load Rn from bus
- R0out..R15out  in  1 each  drive Rn onto bus
- HIin, Loin, PCin, MDRin, MARin, IRin, Yin  in  1 each  load that register
- HIout, Loout, PCout, MDRout, ZHIout, ZLOout, InPortout, Cout, Yout  in  1 each  drive that source onto bus
- Zin  in  1  load Z_register with 64-bit ALU result
- ZHIin, ZLOin  in  1  load ZHI / ZLO
- ZHighSelect, ZLowSelect  in  1  ZHI/ZLO load source select
- MDRread  in  1  MDR load source: 1 = Mdatain, 0 = bus
- IncPC  in  1  force ALU result to bus+1
- ALUSelection  in  5  ALU opcode
- Mdatain  in  32  memory read data
- R0..R15, HI, LO, Y, ZLO, ZHI  out  32 each  register contents
- Z_register  out  64  Z register contents

## Operation
- Bus priority (highest first): R0out..R15out, HIout, Loout, ZHIout, ZLOout, PCout, MDRout, InPortout, Cout, Yout. No strobe → bus = 0.
- Bus values: InPortout → 32'h0 (no input port in this block); Cout → IR[18:0] sign-extended to 32 bits.
- ALU: A = Y, B = bus, 64-bit result; 32-bit ops zero-fill bits 63:32. Opcodes:
  - 00000 ADD A+B; 00001 SUB A−B; 00101 AND; 00110 OR
  - 00010 SHR logical, 01100 SHRA arithmetic, 00011 SHL, 00100 ROR, 01011 ROL; A shifted by B[4:0]
  - 00111 NEG −B; 01000 NOT ~B
  - 01001 MUL signed A×B, full 64 bits
  - 01010 DIV signed: low = A/B, high = A%B; B=0 → result 0
  - any other code → 0
- IncPC=1 overrides ALUSelection: result = {32'h0, B+1}.
- Z loads: Zin → Z_register ← ALU result. ZHIin → ZHI ← ZHighSelect ? live ALU[63:32] : Z_register[63:32]. ZLOin → ZLO ← ZLowSelect ? live ALU[31:0] : Z_register[31:0].
- MDRin: MDR ← MDRread ? Mdatain : bus. MAR, IR, PC, HI, LO, Y, Rn load from bus when their "in" is high.
- Multiple "in" strobes in one cycle all load the same bus value.

## Timing
- All registers positive-edge; each load enable is sampled at the rising edge, one-cycle latency bus→register.
- Bus mux and ALU are purely combinational; same-cycle read-modify-write (e.g. R1out + R1in) loads the pre-edge result.
- Zin with ZLOin/ZHIin and Select=1 in the same cycle: ZLO/ZHI receive the current ALU result (not stale Z_register).
- clr low at any time: every register (R0–R15, HI, LO, PC, IR, MAR, MDR, Y, Z_register, ZHI, ZLO) goes to 0 immediately, held while low; loads resume at the first rising edge after release.
- All outputs reset to 0.

## Test plan
- Reset: drive clr low mid-run → all outputs 0 without a clock edge; release → loads work next edge.
- Memory load: Mdatain=0xA, MDRread=1, MDRin=1 one edge; then MDRout=1, R2in=1 → R2=0xA. Likewise R3=0x2, R1=0x12.
- NOT: R2out+Yin → Y=0xA; then R1out, Yout, ALUSelection=01000, Zin, ZLOin, ZLowSelect → ZLO=0xFFFFFFED; then ZLOout, R0in → R0=0xFFFFFFED.
- Arithmetic: Y=0xA, B=R3=2: ADD → Z=12; SUB → 8; MUL → 20; DIV → ZLO=5, ZHI=0; DIV by 0 → Z=0.
- Shifts/logic: Y=0x80000001, B=1: SHR → 0x40000000; SHRA → 0xC0000000; ROR → 0xC0000000; ROL → 0x00000003; AND/OR with 0x0F.
- Fetch/priority: PC=4, PCout+IncPC+Zin → Z_register=5, ZLO path → PC=5; R0out and R1out together → bus carries R0.

Source files
------------

// File: rtl/cpu_datapath.sv
// Single-bus 32-bit CPU datapath: register file, special registers,
// priority bus mux and a 64-bit result ALU, sequenced by in/out strobes.
module cpu_datapath (
  input  logic        clk,
  input  logic        clr,
  input  logic        R0in,  R1in,  R2in,  R3in,
  input  logic        R4in,  R5in,  R6in,  R7in,
  input  logic        R8in,  R9in,  R10in, R11in,
  input  logic        R12in, R13in, R14in, R15in,
  input  logic        R0out,  R1out,  R2out,  R3out,
  input  logic        R4out,  R5out,  R6out,  R7out,
  input  logic        R8out,  R9out,  R10out, R11out,
  input  logic        R12out, R13out, R14out, R15out,
  input  logic        HIin,
  input  logic        Loin,
  input  logic        PCin,
  input  logic        MDRin,
  input  logic        MARin,
  input  logic        IRin,
  input  logic        Yin,
  input  logic        HIout,
  input  logic        Loout,
  input  logic        PCout,
  input  logic        MDRout,
  input  logic        ZHIout,
  input  logic        ZLOout,
  input  logic        InPortout,
  input  logic        Cout,
  input  logic        Yout,
  input  logic        Zin,
  input  logic        ZHIin,
  input  logic        ZLOin,
  input  logic        ZHighSelect,
  input  logic        ZLowSelect,
  input  logic        MDRread,
  input  logic        IncPC,
  input  logic [4:0]  ALUSelection,
  input  logic [31:0] Mdatain,
  output logic [31:0] R0,  R1,  R2,  R3,
  output logic [31:0] R4,  R5,  R6,  R7,
  output logic [31:0] R8,  R9,  R10, R11,
  output logic [31:0] R12, R13, R14, R15,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] Y,
  output logic [31:0] ZLO,
  output logic [31:0] ZHI,
  output logic [63:0] Z_register
);

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_SHR  = 5'b00010;
  localparam logic [4:0] OP_SHL  = 5'b00011;
  localparam logic [4:0] OP_ROR  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_NEG  = 5'b00111;
  localparam logic [4:0] OP_NOT  = 5'b01000;
  localparam logic [4:0] OP_MUL  = 5'b01001;
  localparam logic [4:0] OP_DIV  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_SHRA = 5'b01100;

  logic [31:0] rf [16];
  logic [31:0] hi_q, lo_q, pc_q, ir_q;
  logic [31:0] mar_q, mdr_q, y_q;
  logic [31:0] zhi_q, zlo_q;
  logic [63:0] z_q;

  logic [15:0] rin, rout;
  logic [3:0]  rsel;
  logic        rhit;
  logic [31:0] bus;
  logic [63:0] alu;

  assign rin = {R15in, R14in, R13in, R12in,
                R11in, R10in, R9in,  R8in,
                R7in,  R6in,  R5in,  R4in,
                R3in,  R2in,  R1in,  R0in};

  assign rout = {R15out, R14out, R13out, R12out,
                 R11out, R10out, R9out,  R8out,
                 R7out,  R6out,  R5out,  R4out,
                 R3out,  R2out,  R1out,  R0out};

  // lowest-numbered register strobe wins
  always_comb begin
    rsel = '0;
    rhit = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      if (rout[i]) begin
        rsel = 4'(i);
        rhit = 1'b1;
      end
    end
  end

  always_comb begin
    priority case (1'b1)
      rhit:      bus = rf[rsel];
      HIout:     bus = hi_q;
      Loout:     bus = lo_q;
      ZHIout:    bus = zhi_q;
      ZLOout:    bus = zlo_q;
      PCout:     bus = pc_q;
      MDRout:    bus = mdr_q;
      InPortout: bus = 32'h0;
      Cout:      bus = {{13{ir_q[18]}}, ir_q[18:0]};
      Yout:      bus = y_q;
      default:   bus = 32'h0;
    endcase
  end

  logic [4:0]         sh;
  logic [63:0]        rot_r, rot_l;
  logic signed [63:0] prod;
  logic [31:0]        quo, rem;

  always_comb begin
    sh    = bus[4:0];
    rot_r = {y_q, y_q} >> sh;
    rot_l = {y_q, y_q} << sh;
    prod  = 64'($signed(y_q)) * 64'($signed(bus));
    quo   = 32'h0;
    rem   = 32'h0;
    if (bus != 32'h0) begin
      quo = $signed(y_q) / $signed(bus);
      rem = $signed(y_q) % $signed(bus);
    end
    alu = 64'h0;
    if (IncPC) begin
      alu = {32'h0, bus + 32'd1};
    end else begin
      case (ALUSelection)
        OP_ADD:  alu = {32'h0, y_q + bus};
        OP_SUB:  alu = {32'h0, y_q - bus};
        OP_AND:  alu = {32'h0, y_q & bus};
        OP_OR:   alu = {32'h0, y_q | bus};
        OP_SHR:  alu = {32'h0, y_q >> sh};
        OP_SHRA: alu = {32'h0, 32'($signed(y_q) >>> sh)};
        OP_SHL:  alu = {32'h0, y_q << sh};
        OP_ROR:  alu = {32'h0, rot_r[31:0]};
        OP_ROL:  alu = {32'h0, rot_l[63:32]};
        OP_NEG:  alu = {32'h0, 32'h0 - bus};
        OP_NOT:  alu = {32'h0, ~bus};
        OP_MUL:  alu = prod;
        OP_DIV:  alu = {rem, quo};
        default: alu = 64'h0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < 16; i++) rf[i] <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      pc_q  <= '0;
      ir_q  <= '0;
      mar_q <= '0;
      mdr_q <= '0;
      y_q   <= '0;
      z_q   <= '0;
      zhi_q <= '0;
      zlo_q <= '0;
    end else begin
      for (int i = 0; i < 16; i++)
        if (rin[i]) rf[i] <= bus;
      if (HIin)  hi_q  <= bus;
      if (Loin)  lo_q  <= bus;
      if (PCin)  pc_q  <= bus;
      if (IRin)  ir_q  <= bus;
      if (MARin) mar_q <= bus;
      if (Yin)   y_q   <= bus;
      if (MDRin) mdr_q <= MDRread ? Mdatain : bus;
      if (Zin)   z_q   <= alu;
      // Select=1 takes the live ALU so a same-cycle Zin is not stale
      if (ZHIin) zhi_q <= ZHighSelect ? alu[63:32] : z_q[63:32];
      if (ZLOin) zlo_q <= ZLowSelect ? alu[31:0] : z_q[31:0];
    end
  end

  assign R0  = rf[0];
  assign R1  = rf[1];
  assign R2  = rf[2];
  assign R3  = rf[3];
  assign R4  = rf[4];
  assign R5  = rf[5];
  assign R6  = rf[6];
  assign R7  = rf[7];
  assign R8  = rf[8];
  assign R9  = rf[9];
  assign R10 = rf[10];
  assign R11 = rf[11];
  assign R12 = rf[12];
  assign R13 = rf[13];
  assign R14 = rf[14];
  assign R15 = rf[15];

  assign HI         = hi_q;
  assign LO         = lo_q;
  assign Y          = y_q;
  assign ZLO        = zlo_q;
  assign ZHI        = zhi_q;
  assign Z_register = z_q;

endmodule

// File: tb/tb_cpu_datapath.sv
// Bench for cpu_datapath: directed register-transfer sequences plus
// randomized strobe cycles checked against a behavioural model.
module tb_cpu_datapath;

  logic        clk = 1'b0;
  logic        clr;
  logic [15:0] rin, rout;
  logic        HIin, Loin, PCin, MDRin, MARin, IRin, Yin;
  logic        HIout, Loout, PCout, MDRout, ZHIout, ZLOout;
  logic        InPortout, Cout, Yout;
  logic        Zin, ZHIin, ZLOin, ZHighSelect, ZLowSelect;
  logic        MDRread, IncPC;
  logic [4:0]  ALUSelection;
  logic [31:0] Mdatain;
  logic [31:0] rq [16];
  logic [31:0] HI, LO, Y, ZLO, ZHI;
  logic [63:0] Z_register;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_r [16];
  logic [31:0] m_hi, m_lo, m_pc, m_ir, m_mar, m_mdr, m_y, m_zhi, m_zlo;
  logic [63:0] m_z;

  always #5 clk = ~clk;

  cpu_datapath dut (
    .clk(clk), .clr(clr),
    .R0in(rin[0]),   .R1in(rin[1]),   .R2in(rin[2]),   .R3in(rin[3]),
    .R4in(rin[4]),   .R5in(rin[5]),   .R6in(rin[6]),   .R7in(rin[7]),
    .R8in(rin[8]),   .R9in(rin[9]),   .R10in(rin[10]), .R11in(rin[11]),
    .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
    .R0out(rout[0]),   .R1out(rout[1]),   .R2out(rout[2]),
    .R3out(rout[3]),   .R4out(rout[4]),   .R5out(rout[5]),
    .R6out(rout[6]),   .R7out(rout[7]),   .R8out(rout[8]),
    .R9out(rout[9]),   .R10out(rout[10]), .R11out(rout[11]),
    .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]),
    .R15out(rout[15]),
    .HIin(HIin), .Loin(Loin), .PCin(PCin), .MDRin(MDRin),
    .MARin(MARin), .IRin(IRin), .Yin(Yin),
    .HIout(HIout), .Loout(Loout), .PCout(PCout), .MDRout(MDRout),
    .ZHIout(ZHIout), .ZLOout(ZLOout), .InPortout(InPortout),
    .Cout(Cout), .Yout(Yout),
    .Zin(Zin), .ZHIin(ZHIin), .ZLOin(ZLOin),
    .ZHighSelect(ZHighSelect), .ZLowSelect(ZLowSelect),
    .MDRread(MDRread), .IncPC(IncPC),
    .ALUSelection(ALUSelection), .Mdatain(Mdatain),
    .R0(rq[0]),   .R1(rq[1]),   .R2(rq[2]),   .R3(rq[3]),
    .R4(rq[4]),   .R5(rq[5]),   .R6(rq[6]),   .R7(rq[7]),
    .R8(rq[8]),   .R9(rq[9]),   .R10(rq[10]), .R11(rq[11]),
    .R12(rq[12]), .R13(rq[13]), .R14(rq[14]), .R15(rq[15]),
    .HI(HI), .LO(LO), .Y(Y), .ZLO(ZLO), .ZHI(ZHI),
    .Z_register(Z_register)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 16; i++)
      chk($sformatf("R%0d", i), {32'h0, rq[i]}, {32'h0, m_r[i]});
    chk("HI", {32'h0, HI}, {32'h0, m_hi});
    chk("LO", {32'h0, LO}, {32'h0, m_lo});
    chk("Y", {32'h0, Y}, {32'h0, m_y});
    chk("ZHI", {32'h0, ZHI}, {32'h0, m_zhi});
    chk("ZLO", {32'h0, ZLO}, {32'h0, m_zlo});
    chk("Z", Z_register, m_z);
  endtask

  task automatic m_reset();
    for (int i = 0; i < 16; i++) m_r[i] = '0;
    {m_hi, m_lo, m_pc, m_ir, m_mar, m_mdr, m_y, m_zhi, m_zlo} = '0;
    m_z = '0;
  endtask

  task automatic idle();
    rin = '0; rout = '0;
    {HIin, Loin, PCin, MDRin, MARin, IRin, Yin} = '0;
    {HIout, Loout, PCout, MDRout, ZHIout, ZLOout} = '0;
    {InPortout, Cout, Yout} = '0;
    {Zin, ZHIin, ZLOin, ZHighSelect, ZLowSelect} = '0;
    {MDRread, IncPC} = '0;
    ALUSelection = '0;
    Mdatain = '0;
  endtask

  function automatic logic [31:0] m_bus();
    for (int i = 0; i < 16; i++)
      if (rout[i]) return m_r[i];
    if (HIout)     return m_hi;
    if (Loout)     return m_lo;
    if (ZHIout)    return m_zhi;
    if (ZLOout)    return m_zlo;
    if (PCout)     return m_pc;
    if (MDRout)    return m_mdr;
    if (InPortout) return 32'h0;
    if (Cout)      return 32'(int'({m_ir[18:0], 13'h0}) >>> 13);
    if (Yout)      return m_y;
    return 32'h0;
  endfunction

  function automatic logic [63:0] m_alu(input logic [31:0] a,
      input logic [31:0] b, input logic [4:0] op, input logic inc);
    logic [31:0] t;
    int s;
    if (inc) return {32'h0, b + 32'd1};
    s = int'(b[4:0]);
    t = a;
    case (op)
      5'd0:  return {32'h0, a + b};
      5'd1:  return {32'h0, a - b};
      5'd5:  return {32'h0, a & b};
      5'd6:  return {32'h0, a | b};
      5'd2:  begin repeat (s) t = {1'b0, t[31:1]};  return {32'h0, t}; end
      5'd12: begin repeat (s) t = {t[31], t[31:1]}; return {32'h0, t}; end
      5'd3:  begin repeat (s) t = {t[30:0], 1'b0};  return {32'h0, t}; end
      5'd4:  begin repeat (s) t = {t[0], t[31:1]};  return {32'h0, t}; end
      5'd11: begin repeat (s) t = {t[30:0], t[31]}; return {32'h0, t}; end
      5'd7:  return {32'h0, 32'h0 - b};
      5'd8:  return {32'h0, ~b};
      5'd9:  return 64'(longint'(int'(a)) * longint'(int'(b)));
      5'd10: begin
        if (b == 0) return 64'h0;
        return {32'(int'(a) % int'(b)), 32'(int'(a) / int'(b))};
      end
      default: return 64'h0;
    endcase
  endfunction

  task automatic step();
    logic [31:0] b;
    logic [63:0] r;
    b = m_bus();
    r = m_alu(m_y, b, ALUSelection, IncPC);
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) if (rin[i]) m_r[i] = b;
    if (HIin)  m_hi  = b;
    if (Loin)  m_lo  = b;
    if (PCin)  m_pc  = b;
    if (IRin)  m_ir  = b;
    if (MARin) m_mar = b;
    if (Yin)   m_y   = b;
    if (MDRin) m_mdr = MDRread ? Mdatain : b;
    if (ZHIin) m_zhi = ZHighSelect ? r[63:32] : m_z[63:32];
    if (ZLOin) m_zlo = ZLowSelect ? r[31:0] : m_z[31:0];
    if (Zin)   m_z   = r;
    check_all();
  endtask

  task automatic load_mem(input int rn, input logic [31:0] v);
    idle(); Mdatain = v; MDRread = 1; MDRin = 1; step();
    idle(); MDRout = 1; rin[rn] = 1; step();
    idle();
  endtask

  task automatic to_y(input int rn);
    idle(); rout[rn] = 1; Yin = 1; step(); idle();
  endtask

  task automatic alu_op(input logic [4:0] op, input int rb);
    idle(); rout[rb] = 1; ALUSelection = op;
    Zin = 1; ZLOin = 1; ZHIin = 1; ZLowSelect = 1; ZHighSelect = 1;
    step(); idle();
  endtask

  task automatic rand_cycle();
    idle();
    if ($urandom_range(3) != 0) rout[$urandom_range(15)] = 1'b1;
    if ($urandom_range(3) == 0) rout[$urandom_range(15)] = 1'b1;
    case ($urandom_range(15))
      0: HIout = 1;  1: Loout = 1;  2: ZHIout = 1;
      3: ZLOout = 1; 4: PCout = 1;  5: MDRout = 1;
      6: InPortout = 1; 7: Cout = 1; 8: Yout = 1;
      default: ;
    endcase
    rin = 16'($urandom & $urandom & $urandom);
    HIin  = ($urandom_range(3) == 0);
    Loin  = ($urandom_range(3) == 0);
    PCin  = ($urandom_range(3) == 0);
    MDRin = ($urandom_range(3) == 0);
    MARin = ($urandom_range(3) == 0);
    IRin  = ($urandom_range(3) == 0);
    Yin   = ($urandom_range(2) == 0);
    Zin   = ($urandom_range(1) == 0);
    ZHIin = ($urandom_range(1) == 0);
    ZLOin = ($urandom_range(1) == 0);
    ZHighSelect  = ($urandom_range(1) == 0);
    ZLowSelect   = ($urandom_range(1) == 0);
    MDRread      = ($urandom_range(1) == 0);
    IncPC        = ($urandom_range(7) == 0);
    ALUSelection = 5'($urandom_range(15));
    Mdatain      = (($urandom_range(1) == 0) ? $urandom : $urandom_range(40));
    if (ALUSelection == 5'd10 && m_y == 32'h8000_0000 &&
        m_bus() == 32'hFFFF_FFFF)
      ALUSelection = 5'd0;
    step();
  endtask

  initial begin
    idle();
    m_reset();
    clr = 1'b0;
    #12;
    check_all();
    clr = 1'b1;

    load_mem(2, 32'hA);
    chk("mem_r2", {32'h0, rq[2]}, 64'hA);
    load_mem(3, 32'h2);
    load_mem(1, 32'h12);
    chk("mem_r1", {32'h0, rq[1]}, 64'h12);
    to_y(2);
    chk("y_a", {32'h0, Y}, 64'hA);

    idle(); rout[1] = 1; Yout = 1; ALUSelection = 5'b01000;
    Zin = 1; ZLOin = 1; ZLowSelect = 1; step();
    chk("not_zlo", {32'h0, ZLO}, 64'hFFFF_FFED);
    idle(); ZLOout = 1; rin[0] = 1; step();
    chk("not_r0", {32'h0, rq[0]}, 64'hFFFF_FFED);

    alu_op(5'b00000, 3); chk("add", Z_register, 64'd12);
    alu_op(5'b00001, 3); chk("sub", Z_register, 64'd8);
    alu_op(5'b01001, 3); chk("mul", Z_register, 64'd20);
    alu_op(5'b01010, 3);
    chk("div_lo", {32'h0, ZLO}, 64'd5);
    chk("div_hi", {32'h0, ZHI}, 64'd0);
    alu_op(5'b01010, 4); chk("div0", Z_register, 64'd0);

    load_mem(5, 32'h8000_0001);
    to_y(5);
    load_mem(6, 32'h1);
    alu_op(5'b00010, 6); chk("shr", Z_register, 64'h4000_0000);
    alu_op(5'b01100, 6); chk("shra", Z_register, 64'hC000_0000);
    alu_op(5'b00100, 6); chk("ror", Z_register, 64'hC000_0000);
    alu_op(5'b01011, 6); chk("rol", Z_register, 64'h0000_0003);
    load_mem(7, 32'hF);
    alu_op(5'b00101, 7); chk("and", Z_register, 64'h0000_0001);
    alu_op(5'b00110, 7); chk("or", Z_register, 64'h8000_000F);

    load_mem(8, 32'h4);
    idle(); rout[8] = 1; PCin = 1; step();
    idle(); PCout = 1; IncPC = 1; ALUSelection = 5'b00001; Zin = 1; step();
    chk("incpc_z", Z_register, 64'd5);
    idle(); ZLOin = 1; step();
    idle(); ZLOout = 1; PCin = 1; rin[9] = 1; step();
    chk("zlo_r9", {32'h0, rq[9]}, 64'd5);
    idle(); PCout = 1; rin[10] = 1; step();
    chk("pc_r10", {32'h0, rq[10]}, 64'd5);
    idle(); rout[0] = 1; rout[1] = 1; rin[11] = 1; step();
    chk("prio_r0", {32'h0, rq[11]}, 64'hFFFF_FFED);

    load_mem(12, 32'h1234_0005);
    idle(); rout[12] = 1; IRin = 1; step();
    idle(); Cout = 1; rin[13] = 1; step();
    chk("cout_sext", {32'h0, rq[13]}, 64'hFFFC_0005);

    idle();
    #2;
    clr = 1'b0;
    #1;
    m_reset();
    check_all();
    chk("rst_z", Z_register, 64'h0);
    @(posedge clk);
    #1;
    check_all();
    clr = 1'b1;
    load_mem(2, 32'h55);
    chk("post_rst", {32'h0, rq[2]}, 64'h55);

    repeat (500) rand_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
